// File: rtl/fp_special_pkg.sv
// Shared definitions for the IEEE-754 special-case resolver.
//   OP_*            : operation encodings carried on the op port
//   fp_cls_e        : operand class produced by fp_classify
//   canonical_qnan  : canonical quiet NaN word (sign 0, exp all ones,
//                     mantissa MSB set) for a given exponent/mantissa width,
//                     returned right-aligned in 64 bits (formats up to 64 bits)
package fp_special_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_INF,
    CLS_QNAN,
    CLS_SNAN,
    CLS_FINITE
  } fp_cls_e;

  function automatic logic [63:0] canonical_qnan(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 operand classifier.
//   word_i : operand word {sign, exponent, mantissa}
//   cls_o  : zero / inf / quiet NaN / signalling NaN / finite (subnormals are finite)
//   sign_o : sign bit of the operand
module fp_classify
  import fp_special_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic [W-1:0] word_i,
  output fp_cls_e      cls_o,
  output logic         sign_o
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;

  assign exp_f  = word_i[W-2:MAN_W];
  assign man_f  = word_i[MAN_W-1:0];
  assign sign_o = word_i[W-1];

  always_comb begin
    cls_o = CLS_FINITE;
    if (exp_f == '0 && man_f == '0) begin
      cls_o = CLS_ZERO;
    end else if (&exp_f) begin
      if (man_f == '0)         cls_o = CLS_INF;
      else if (man_f[MAN_W-1]) cls_o = CLS_QNAN;
      else                     cls_o = CLS_SNAN;
    end
  end

endmodule

// File: rtl/fp_special_pipe.sv
// Two-stage pipelined IEEE-754 special-case resolver for add, sub and mul.
//   clk, rst               : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready      : operand pair handshake (a, b, op)
//   out_valid/out_ready    : result handshake (out, check_special)
//   out                    : resolved special result, zero when check_special=0
//   check_special          : result resolved here, downstream bypasses arithmetic
//   flag_invalid           : sticky invalid flag, set as an invalid result is consumed
//   flag_clear             : synchronous clear of flag_invalid (a same-cycle set wins)
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. A producer holding valid keeps its data stable; valid never depends on
// ready. Stage readiness: s2_ready = !out_valid | out_ready,
// in_ready = (!s1_valid | s2_ready) & !rst, so the pipe holds two items when
// stalled and drains/refills in the same cycle without loss.
module fp_special_pipe
  import fp_special_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out,
  output logic         check_special,
  output logic         flag_invalid,
  input  logic         flag_clear
);

  localparam logic [W-1:0] QNAN    = W'(canonical_qnan(EXP_W, MAN_W));
  localparam logic [W-2:0] INF_MAG = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};

  fp_cls_e cls_a, cls_b;
  logic    sign_a, sign_b;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .word_i (a), .cls_o (cls_a), .sign_o (sign_a)
  );
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .word_i (b), .cls_o (cls_b), .sign_o (sign_b)
  );

  // Stage 1 registers
  logic         s1_valid_q, s1_valid_d;
  fp_cls_e      s1_cls_a_q, s1_cls_a_d, s1_cls_b_q, s1_cls_b_d;
  logic         s1_sa_q, s1_sa_d, s1_sb_q, s1_sb_d;
  logic [1:0]   s1_op_q, s1_op_d;
  logic [W-2:0] s1_mag_q, s1_mag_d;

  // Stage 2 registers
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_q, out_d;
  logic         spec_q, spec_d;
  logic         inv_q, inv_d;
  logic         flag_q, flag_d;

  logic         s2_ready, s1_ready, accept;
  logic [W-1:0] res;
  logic         res_spec, res_inv;
  logic         nan_any, snan_any, s_mul;

  assign s2_ready = !out_valid_q || out_ready;
  assign s1_ready = !s1_valid_q || s2_ready;
  assign in_ready = s1_ready && !rst;
  assign accept   = in_valid && in_ready;

  // Stage 1 captures classes and signs. For add/sub the b sign is stored as
  // the effective sign (flipped for subtract); mul never flips. Only one
  // magnitude is kept: the one a zero+finite sum passes through (b when a is
  // zero, otherwise a).
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_cls_a_d = s1_cls_a_q;
    s1_cls_b_d = s1_cls_b_q;
    s1_sa_d    = s1_sa_q;
    s1_sb_d    = s1_sb_q;
    s1_op_d    = s1_op_q;
    s1_mag_d   = s1_mag_q;
    if (s1_ready) s1_valid_d = accept;
    if (accept) begin
      s1_cls_a_d = cls_a;
      s1_cls_b_d = cls_b;
      s1_sa_d    = sign_a;
      s1_sb_d    = sign_b ^ (op == OP_SUB);
      s1_op_d    = op;
      s1_mag_d   = (cls_a == CLS_ZERO) ? b[W-2:0] : a[W-2:0];
    end
  end

  // Special-case resolution from stage 1 contents
  always_comb begin
    res      = '0;
    res_spec = 1'b1;
    res_inv  = 1'b0;
    snan_any = (s1_cls_a_q == CLS_SNAN) || (s1_cls_b_q == CLS_SNAN);
    nan_any  = snan_any || (s1_cls_a_q == CLS_QNAN) || (s1_cls_b_q == CLS_QNAN);
    s_mul    = s1_sa_q ^ s1_sb_q;
    if (s1_op_q == OP_RSV) begin
      res     = QNAN;
      res_inv = 1'b1;
    end else if (nan_any) begin
      res = QNAN;
    end else if (s1_op_q == OP_MUL) begin
      if ((s1_cls_a_q == CLS_INF && s1_cls_b_q == CLS_ZERO) ||
          (s1_cls_a_q == CLS_ZERO && s1_cls_b_q == CLS_INF)) begin
        res     = QNAN;
        res_inv = 1'b1;
      end else if (s1_cls_a_q == CLS_INF || s1_cls_b_q == CLS_INF) begin
        res = {s_mul, INF_MAG};
      end else if (s1_cls_a_q == CLS_ZERO || s1_cls_b_q == CLS_ZERO) begin
        res = {s_mul, {(W-1){1'b0}}};
      end else begin
        res_spec = 1'b0;
      end
    end else begin
      if (s1_cls_a_q == CLS_INF && s1_cls_b_q == CLS_INF) begin
        if (s1_sa_q == s1_sb_q) begin
          res = {s1_sa_q, INF_MAG};
        end else begin
          res     = QNAN;
          res_inv = 1'b1;
        end
      end else if (s1_cls_a_q == CLS_INF) begin
        res = {s1_sa_q, INF_MAG};
      end else if (s1_cls_b_q == CLS_INF) begin
        res = {s1_sb_q, INF_MAG};
      end else if (s1_cls_a_q == CLS_ZERO && s1_cls_b_q == CLS_ZERO) begin
        res = {s1_sa_q & s1_sb_q, {(W-1){1'b0}}};
      end else if (s1_cls_a_q == CLS_ZERO) begin
        res = {s1_sb_q, s1_mag_q};
      end else if (s1_cls_b_q == CLS_ZERO) begin
        res = {s1_sa_q, s1_mag_q};
      end else begin
        res_spec = 1'b0;
      end
    end
    if (snan_any) res_inv = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    spec_d      = spec_q;
    inv_d       = inv_q;
    if (s2_ready) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_d  = res;
        spec_d = res_spec;
        inv_d  = res_inv;
      end
    end
    flag_d = flag_q;
    if (out_valid_q && out_ready && inv_q) flag_d = 1'b1;
    else if (flag_clear)                   flag_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_cls_a_q  <= CLS_ZERO;
      s1_cls_b_q  <= CLS_ZERO;
      s1_sa_q     <= 1'b0;
      s1_sb_q     <= 1'b0;
      s1_op_q     <= OP_ADD;
      s1_mag_q    <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      spec_q      <= 1'b0;
      inv_q       <= 1'b0;
      flag_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_cls_a_q  <= s1_cls_a_d;
      s1_cls_b_q  <= s1_cls_b_d;
      s1_sa_q     <= s1_sa_d;
      s1_sb_q     <= s1_sb_d;
      s1_op_q     <= s1_op_d;
      s1_mag_q    <= s1_mag_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      spec_q      <= spec_d;
      inv_q       <= inv_d;
      flag_q      <= flag_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out           = out_q;
  assign check_special = spec_q;
  assign flag_invalid  = flag_q;

endmodule

// File: tb/tb_fp_special_pipe.sv
// Self-checking bench for fp_special_pipe: directed cases from the test plan,
// backpressure and reset-mid-stall, a half-precision instance, and a random
// phase scored against a field-level model of the IEEE special-case rules.
module tb_fp_special_pipe;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- single-precision DUT ----------------
  logic         in_valid = 1'b0, in_ready;
  logic [W-1:0] a = '0, b = '0, out;
  logic [1:0]   op = 2'b00;
  logic         out_valid, out_ready = 1'b1, check_special, flag_invalid;
  logic         flag_clear = 1'b0;

  fp_special_pipe u_dut (
    .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready),
    .a (a), .b (b), .op (op), .out_valid (out_valid), .out_ready (out_ready),
    .out (out), .check_special (check_special), .flag_invalid (flag_invalid),
    .flag_clear (flag_clear)
  );

  // ---------------- half-precision DUT ----------------
  logic        h_in_valid = 1'b0, h_in_ready, h_out_valid, h_spec, h_flag;
  logic [15:0] h_a = '0, h_b = '0, h_out;
  logic [1:0]  h_op = 2'b00;
  logic        h_out_ready = 1'b1, h_flag_clear = 1'b0;

  fp_special_pipe #(.EXP_W(5), .MAN_W(10)) u_dut_h (
    .clk (clk), .rst (rst), .in_valid (h_in_valid), .in_ready (h_in_ready),
    .a (h_a), .b (h_b), .op (h_op), .out_valid (h_out_valid), .out_ready (h_out_ready),
    .out (h_out), .check_special (h_spec), .flag_invalid (h_flag),
    .flag_clear (h_flag_clear)
  );

  int checks = 0;
  int failures = 0;
  logic [W+1:0] exp_q[$];   // {check_special, invalid, out}
  logic flag_exp = 1'b0;
  logic rnd_mode = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Returns {check_special, invalid, result} for a word of the given widths.
  function automatic logic [65:0] model(input logic [63:0] x, input logic [63:0] y,
                                        input logic [1:0] o, input int ew, input int mw);
    logic [63:0] emax, mmask, sbit, qn, inf_mag, ex, mx, ey, my, res;
    logic x_nan, y_nan, x_snan, y_snan, x_inf, y_inf, x_zero, y_zero;
    logic sx, sy, se, sp, inv;
    emax    = (64'd1 << ew) - 64'd1;
    mmask   = (64'd1 << mw) - 64'd1;
    sbit    = 64'd1 << (ew + mw);
    qn      = (emax << mw) | (64'd1 << (mw - 1));
    inf_mag = emax << mw;
    ex = (x >> mw) & emax;  mx = x & mmask;
    ey = (y >> mw) & emax;  my = y & mmask;
    x_nan  = (ex == emax) && (mx != 0);
    y_nan  = (ey == emax) && (my != 0);
    x_snan = x_nan && (((mx >> (mw - 1)) & 64'd1) == 0);
    y_snan = y_nan && (((my >> (mw - 1)) & 64'd1) == 0);
    x_inf  = (ex == emax) && (mx == 0);
    y_inf  = (ey == emax) && (my == 0);
    x_zero = (ex == 0) && (mx == 0);
    y_zero = (ey == 0) && (my == 0);
    sx = (x & sbit) != 0;
    sy = (y & sbit) != 0;
    sp = 1'b1;
    inv = x_snan || y_snan;
    res = 64'd0;
    if (o == 2'b11) begin
      res = qn; inv = 1'b1;
    end else if (x_nan || y_nan) begin
      res = qn;
    end else if (o == 2'b10) begin
      se = sx ^ sy;
      if ((x_inf && y_zero) || (x_zero && y_inf)) begin res = qn; inv = 1'b1; end
      else if (x_inf || y_inf)   res = (se ? sbit : 64'd0) | inf_mag;
      else if (x_zero || y_zero) res = se ? sbit : 64'd0;
      else sp = 1'b0;
    end else begin
      se = sy ^ (o == 2'b01);
      if (x_inf && y_inf) begin
        if (sx == se) res = x;
        else begin res = qn; inv = 1'b1; end
      end
      else if (x_inf)            res = x;
      else if (y_inf)            res = (se ? sbit : 64'd0) | inf_mag;
      else if (x_zero && y_zero) res = (sx && se) ? sbit : 64'd0;
      else if (x_zero)           res = (y & ~sbit) | (se ? sbit : 64'd0);
      else if (y_zero)           res = x;
      else sp = 1'b0;
    end
    return {sp, inv, res};
  endfunction

  // ---------------- scoreboard / compare process ----------------
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_out = '0;
  logic         prev_spec = 1'b0;

  always @(negedge clk) begin : cmp
    logic [W+1:0] e;
    logic set_now;
    if (rst) begin
      exp_q.delete();
      flag_exp   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      set_now = 1'b0;
      chk("flag_invalid", flag_invalid, flag_exp);
      if (prev_stall) begin
        chk("stall_valid_hold", out_valid, 1);
        chk("stall_out_hold", out, prev_out);
        chk("stall_spec_hold", check_special, prev_spec);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", out_valid, 0);
        end else begin
          e = exp_q[0];
          chk("out", out, e[W-1:0]);
          chk("check_special", check_special, e[W+1]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            set_now = e[W];
          end
        end
      end
      if (set_now)         flag_exp = 1'b1;
      else if (flag_clear) flag_exp = 1'b0;
      prev_stall = out_valid && !out_ready;
      prev_out   = out;
      prev_spec  = check_special;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [1:0] top);
    logic [65:0] m;
    int waitc;
    bit done;
    waitc = 0;
    done = 1'b0;
    in_valid = 1'b1; a = ta; b = tb; op = top;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        m = model({32'd0, ta}, {32'd0, tb}, top, 8, 23);
        exp_q.push_back({m[65:64], m[W-1:0]});
        done = 1'b1;
      end else if (++waitc > 300) begin
        chk("send_timeout", in_ready, 1);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk); n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // One beat with out_ready high; pins latency and result against literals.
  task automatic check_one(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic [1:0] top, input logic [W-1:0] eo, input logic es);
    int n;
    out_ready = 1'b1;
    send(ta, tb, top);
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 10);
    chk({name, "_latency"}, n, 2);
    chk({name, "_out"}, out, eo);
    chk({name, "_spec"}, check_special, es);
    wait_drain();
  endtask

  function automatic logic [W-1:0] rand_operand();
    logic [W-1:0] v;
    logic s;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 5))
      0:       v = 32'h0000_0000;
      1:       v = 32'h7F80_0000;
      2:       v = {9'h0FF, 1'b1, 22'($urandom)};
      3:       v = {9'h0FF, 1'b0, 22'($urandom) | 22'd1};
      4:       v = {9'h000, 23'($urandom) | 23'd1};
      default: v = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
    endcase
    v[31] = s;
    return v;
  endfunction

  // Random consumer backpressure and flag clears during the random phase.
  always @(posedge clk) begin
    if (rnd_mode) begin
      #1;
      out_ready  = ($urandom_range(0, 3) != 0);
      flag_clear = ($urandom_range(0, 9) == 0);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog_timeout got=running expected=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    logic [65:0] m;
    int n;
    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out", out, 0);
    chk("post_rst_spec", check_special, 0);
    chk("post_rst_flag", flag_invalid, 0);
    @(posedge clk); #1;

    // model pins against hand-computed literals
    m = model(64'h0000_0000, 64'h406C_CCCD, 2'b01, 8, 23);
    chk("model_pin_zero_sub", m, {2'b10, 64'hC06C_CCCD});
    m = model(64'hFF80_0001, 64'h406C_CCCD, 2'b00, 8, 23);
    chk("model_pin_snan", m, {2'b11, 64'h7FC0_0000});
    m = model(64'h7C00, 64'h0000, 2'b10, 5, 10);
    chk("model_pin_half_inf_zero", m, {2'b11, 64'h7E00});

    // directed
    check_one("zero_plus_fin", 32'h0000_0000, 32'h406C_CCCD, 2'b00, 32'h406C_CCCD, 1'b1);
    chk("zero_plus_fin_flag", flag_invalid, 0);
    check_one("inf_minus_inf", 32'h7F80_0000, 32'hFF80_0000, 2'b00, 32'h7FC0_0000, 1'b1);
    chk("inf_minus_inf_flag", flag_invalid, 1);
    flag_clear = 1'b1;
    @(posedge clk); #1;
    flag_clear = 1'b0;
    @(negedge clk);
    chk("flag_cleared", flag_invalid, 0);
    @(posedge clk); #1;
    check_one("zero_sub_fin", 32'h0000_0000, 32'h406C_CCCD, 2'b01, 32'hC06C_CCCD, 1'b1);
    check_one("zero_mul_fin", 32'h0000_0000, 32'h406C_CCCD, 2'b10, 32'h0000_0000, 1'b1);
    check_one("negz_sub_z",   32'h8000_0000, 32'h0000_0000, 2'b01, 32'h8000_0000, 1'b1);
    check_one("fin_plus_fin", 32'h406C_CCCD, 32'h406C_CCCD, 2'b00, 32'h0000_0000, 1'b0);
    check_one("reserved_op",  32'h406C_CCCD, 32'h0000_0000, 2'b11, 32'h7FC0_0000, 1'b1);

    // backpressure: two accepted, third refused until release
    out_ready = 1'b0;
    send(32'h7F80_0000, 32'h0000_0000, 2'b00);
    send(32'h0000_0000, 32'hFF80_0000, 2'b00);
    in_valid = 1'b1; a = 32'hFF80_0001; b = 32'h406C_CCCD; op = 2'b00;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready_full", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'hFF80_0001, 32'h406C_CCCD, 2'b00);
    wait_drain();
    chk("bp_flag_from_snan", flag_invalid, 1);

    // reset while stalled discards both in-flight items
    out_ready = 1'b0;
    send(32'h7F80_0000, 32'h0000_0000, 2'b10);
    send(32'hFF80_0000, 32'h3F80_0000, 2'b10);
    @(negedge clk);
    chk("pre_rst_out_valid", out_valid, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out", out, 0);
    chk("midrst_spec", check_special, 0);
    chk("midrst_flag", flag_invalid, 0);
    chk("midrst_in_ready_after", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // half precision: inf * zero
    h_in_valid = 1'b1; h_a = 16'h7C00; h_b = 16'h0000; h_op = 2'b10;
    @(negedge clk);
    chk("half_in_ready", h_in_ready, 1);
    @(posedge clk); #1;
    h_in_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!h_out_valid && n < 10);
    chk("half_out", h_out, 16'h7E00);
    chk("half_spec", h_spec, 1);
    @(negedge clk);
    chk("half_flag", h_flag, 1);
    @(posedge clk); #1;

    // random phase
    rnd_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send(rand_operand(), rand_operand(), ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    rnd_mode = 1'b0;
    #1;
    out_ready  = 1'b1;
    flag_clear = 1'b0;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
